// File: rtl/svm_fin_sequencer.sv
// Upstream sequencer for the SVM fin interface: one entry becomes a valence beat then an arousal beat.
// Optional perf counters (entry_count, stall_count) are built when SVM_FIN_SEQ_PERF_EN is defined.
module svm_fin_sequencer #(
  parameter int NBITS         = 9,
  parameter int VSUP_WIDTH    = 120,
  parameter int ASUP_WIDTH    = 155,
  parameter int F_WIDTH       = 214,
  parameter int SUP_WIDTH     = (VSUP_WIDTH > ASUP_WIDTH) ? VSUP_WIDTH : ASUP_WIDTH,
  parameter int LOG_SUP_WIDTH = $clog2(SUP_WIDTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  ent_valid,
  output logic                                  ent_ready,
  input  logic [NBITS*F_WIDTH-1:0]              ent_v_features,
  input  logic [NBITS*F_WIDTH-1:0]              ent_a_features,
  input  logic [NBITS*VSUP_WIDTH*F_WIDTH-1:0]   v_support,
  input  logic [NBITS*ASUP_WIDTH*F_WIDTH-1:0]   a_support,
  input  logic [NBITS*VSUP_WIDTH-1:0]           v_alpha,
  input  logic [NBITS*ASUP_WIDTH-1:0]           a_alpha,
  input  logic [2*NBITS+LOG_SUP_WIDTH-1:0]      v_intercept,
  input  logic [2*NBITS+LOG_SUP_WIDTH-1:0]      a_intercept,
  output logic [NBITS*F_WIDTH-1:0]              in_features,
  output logic [NBITS*SUP_WIDTH*F_WIDTH-1:0]    in_support,
  output logic [NBITS*SUP_WIDTH-1:0]            in_alpha,
  output logic [2*NBITS+LOG_SUP_WIDTH-1:0]      in_intercept,
  output logic                                  fin_valid,
  input  logic                                  fin_ready,
  output logic                                  fin_modality
`ifdef SVM_FIN_SEQ_PERF_EN
  ,
  output logic [31:0]                           entry_count,
  output logic [31:0]                           stall_count
`endif
);

  localparam int FW  = NBITS * F_WIDTH;
  localparam int VSW = NBITS * VSUP_WIDTH * F_WIDTH;
  localparam int ASW = NBITS * ASUP_WIDTH * F_WIDTH;
  localparam int VAW = NBITS * VSUP_WIDTH;
  localparam int AAW = NBITS * ASUP_WIDTH;

  typedef enum logic [1:0] {IDLE, SEND_V, SEND_A} state_t;

  state_t          state_q, state_d;
  logic            ent_ready_q, ent_ready_d;
  logic            fin_valid_q, fin_valid_d;
  logic            fin_modality_q, fin_modality_d;
  logic [FW-1:0]   feat_q, feat_d;
  logic [FW-1:0]   a_feat_q, a_feat_d;

  always_comb begin
    state_d        = state_q;
    fin_valid_d    = fin_valid_q;
    fin_modality_d = fin_modality_q;
    feat_d         = feat_q;
    a_feat_d       = a_feat_q;
    case (state_q)
      IDLE: begin
        if (ent_valid && ent_ready_q) begin
          state_d        = SEND_V;
          fin_valid_d    = 1'b1;
          fin_modality_d = 1'b0;
          feat_d         = ent_v_features;
          a_feat_d       = ent_a_features;
        end
      end
      SEND_V: begin
        // feat_q is the beat's output register; arousal vector moves in on the valence transfer
        if (fin_ready) begin
          state_d        = SEND_A;
          fin_modality_d = 1'b1;
          feat_d         = a_feat_q;
        end
      end
      SEND_A: begin
        if (fin_ready) begin
          state_d        = IDLE;
          fin_valid_d    = 1'b0;
          fin_modality_d = 1'b0;
          feat_d         = '0;
          a_feat_d       = '0;
        end
      end
      default: begin
        state_d        = IDLE;
        fin_valid_d    = 1'b0;
        fin_modality_d = 1'b0;
      end
    endcase
    ent_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      ent_ready_q    <= 1'b0;
      fin_valid_q    <= 1'b0;
      fin_modality_q <= 1'b0;
      feat_q         <= '0;
      a_feat_q       <= '0;
    end else begin
      state_q        <= state_d;
      ent_ready_q    <= ent_ready_d;
      fin_valid_q    <= fin_valid_d;
      fin_modality_q <= fin_modality_d;
      feat_q         <= feat_d;
      a_feat_q       <= a_feat_d;
    end
  end

  // Model selection keys off registered beat state; rows beyond the active model read as zero.
  always_comb begin
    in_support   = '0;
    in_alpha     = '0;
    in_intercept = '0;
    if (fin_valid_q) begin
      if (!fin_modality_q) begin
        in_support[VSW-1:0] = v_support;
        in_alpha[VAW-1:0]   = v_alpha;
        in_intercept        = v_intercept;
      end else begin
        in_support[ASW-1:0] = a_support;
        in_alpha[AAW-1:0]   = a_alpha;
        in_intercept        = a_intercept;
      end
    end
  end

  assign ent_ready    = ent_ready_q;
  assign fin_valid    = fin_valid_q;
  assign fin_modality = fin_modality_q;
  assign in_features  = feat_q;

`ifdef SVM_FIN_SEQ_PERF_EN
  logic [31:0] entry_count_q, entry_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    entry_count_d = entry_count_q;
    stall_count_d = stall_count_q;
    if (state_q == SEND_A && fin_ready) entry_count_d = entry_count_q + 32'd1;
    if (fin_valid_q && !fin_ready)      stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      entry_count_q <= entry_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign entry_count = entry_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_svm_fin_sequencer.sv
// Directed bench for svm_fin_sequencer with a small configuration (F=4, VSUP=2, ASUP=3).
module tb_svm_fin_sequencer;
  localparam int NBITS = 9;
  localparam int F     = 4;
  localparam int VS    = 2;
  localparam int AS    = 3;
  localparam int S     = 3;
  localparam int IW    = 2*NBITS + 2;

  logic clk, rst, ent_valid, ent_ready, fin_valid, fin_ready, fin_modality;
  logic [NBITS*F-1:0]    ent_v_features, ent_a_features, in_features;
  logic [NBITS*VS*F-1:0] v_support;
  logic [NBITS*AS*F-1:0] a_support;
  logic [NBITS*VS-1:0]   v_alpha;
  logic [NBITS*AS-1:0]   a_alpha;
  logic [IW-1:0]         v_intercept, a_intercept, in_intercept;
  logic [NBITS*S*F-1:0]  in_support;
  logic [NBITS*S-1:0]    in_alpha;
`ifdef SVM_FIN_SEQ_PERF_EN
  logic [31:0] entry_count, stall_count;
`endif

  svm_fin_sequencer #(.NBITS(NBITS), .VSUP_WIDTH(VS), .ASUP_WIDTH(AS), .F_WIDTH(F)) dut (
    .clk(clk), .rst(rst), .ent_valid(ent_valid), .ent_ready(ent_ready),
    .ent_v_features(ent_v_features), .ent_a_features(ent_a_features),
    .v_support(v_support), .a_support(a_support), .v_alpha(v_alpha), .a_alpha(a_alpha),
    .v_intercept(v_intercept), .a_intercept(a_intercept),
    .in_features(in_features), .in_support(in_support), .in_alpha(in_alpha),
    .in_intercept(in_intercept), .fin_valid(fin_valid), .fin_ready(fin_ready),
    .fin_modality(fin_modality)
`ifdef SVM_FIN_SEQ_PERF_EN
    , .entry_count(entry_count), .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NBITS*F-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
    logic [NBITS*F-1:0] r;
    r[0*NBITS +: NBITS] = NBITS'(e0);
    r[1*NBITS +: NBITS] = NBITS'(e1);
    r[2*NBITS +: NBITS] = NBITS'(e2);
    r[3*NBITS +: NBITS] = NBITS'(e3);
    return r;
  endfunction

  logic [NBITS*S*F-1:0] exp_vsup, exp_asup;
  logic [NBITS*S-1:0]   exp_valpha, exp_aalpha;
  logic [NBITS*F-1:0]   fv1, fa1, fv2, fa2, fv3, fa3, fv4, fa4;
  int xfers, ec0;

  initial begin
    // Static model: valence element (r,k) = 4r+k+1, arousal element = -(4r+k+10)
    for (int r = 0; r < S; r++)
      for (int k = 0; k < F; k++) begin
        exp_asup[(r*F+k)*NBITS +: NBITS] = NBITS'(-(4*r+k+10));
        exp_vsup[(r*F+k)*NBITS +: NBITS] = (r < VS) ? NBITS'(4*r+k+1) : '0;
      end
    v_support   = exp_vsup[NBITS*VS*F-1:0];
    a_support   = exp_asup;
    exp_valpha  = {9'd0, 9'd11, 9'd10};
    exp_aalpha  = {9'h1EC, 9'd21, 9'd20};
    v_alpha     = exp_valpha[NBITS*VS-1:0];
    a_alpha     = exp_aalpha;
    v_intercept = 20'h12345;
    a_intercept = 20'hABCDE;

    fv1 = pack4(1, -2, 3, -4);   fa1 = pack4(5, 6, -7, 8);
    fv2 = pack4(100, -100, 7, 0); fa2 = pack4(-1, -1, 255, -256);
    fv3 = pack4(9, 8, 7, 6);     fa3 = pack4(-9, -8, -7, -6);
    fv4 = pack4(2, 4, 6, 8);     fa4 = pack4(1, 3, 5, 7);

    rst = 1'b1; ent_valid = 1'b0; fin_ready = 1'b0;
    ent_v_features = '0; ent_a_features = '0;

    // Scenario 1: reset and idle
    tick(); tick();
    chk("rst_fin_valid", 128'(fin_valid), 128'(0));
    chk("rst_ent_ready", 128'(ent_ready), 128'(0));
    chk("rst_modality", 128'(fin_modality), 128'(0));
    chk("rst_features", 128'(in_features), 128'(0));
    chk("rst_support", 128'(in_support), 128'(0));
    chk("rst_alpha", 128'(in_alpha), 128'(0));
    chk("rst_intercept", 128'(in_intercept), 128'(0));
    rst = 1'b0;
    tick();
    chk("idle_ent_ready", 128'(ent_ready), 128'(1));
    chk("idle_fin_valid", 128'(fin_valid), 128'(0));

    // Scenario 2: single entry, fin_ready held high
    ent_v_features = fv1; ent_a_features = fa1; ent_valid = 1'b1; fin_ready = 1'b1;
    tick();
    ent_valid = 1'b0;
    chk("s2_v_valid", 128'(fin_valid), 128'(1));
    chk("s2_v_mod", 128'(fin_modality), 128'(0));
    chk("s2_v_feat", 128'(in_features), 128'(fv1));
    chk("s2_v_sup", 128'(in_support), 128'(exp_vsup));
    chk("s2_v_row2_zero", 128'(in_support[2*F*NBITS +: F*NBITS]), 128'(0));
    chk("s2_v_alpha", 128'(in_alpha), 128'(exp_valpha));
    chk("s2_v_icpt", 128'(in_intercept), 128'(20'h12345));
    chk("s2_v_ent_ready", 128'(ent_ready), 128'(0));
    tick();
    chk("s2_a_valid", 128'(fin_valid), 128'(1));
    chk("s2_a_mod", 128'(fin_modality), 128'(1));
    chk("s2_a_feat", 128'(in_features), 128'(fa1));
    chk("s2_a_sup", 128'(in_support), 128'(exp_asup));
    chk("s2_a_alpha", 128'(in_alpha), 128'(exp_aalpha));
    chk("s2_a_icpt", 128'(in_intercept), 128'(20'hABCDE));
    tick();
    chk("s2_end_valid", 128'(fin_valid), 128'(0));
    chk("s2_end_ready", 128'(ent_ready), 128'(1));

    // Scenario 3: five stall cycles on the valence beat
    ent_v_features = fv2; ent_a_features = fa2; ent_valid = 1'b1; fin_ready = 1'b0;
    tick();
    ent_valid = 1'b0;
    chk("s3_v_feat", 128'(in_features), 128'(fv2));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s3_hold_valid", 128'(fin_valid), 128'(1));
      chk("s3_hold_mod", 128'(fin_modality), 128'(0));
      chk("s3_hold_feat", 128'(in_features), 128'(fv2));
      chk("s3_hold_sup", 128'(in_support), 128'(exp_vsup));
      chk("s3_hold_alpha", 128'(in_alpha), 128'(exp_valpha));
    end
    tick();
    chk("s3_still_v", 128'(fin_modality), 128'(0));
`ifdef SVM_FIN_SEQ_PERF_EN
    chk("s3_stall_count", 128'(stall_count), 128'(5));
`endif
    fin_ready = 1'b1;
    tick();
    chk("s3_a_mod", 128'(fin_modality), 128'(1));
    chk("s3_a_feat", 128'(in_features), 128'(fa2));
    tick();
    chk("s3_end_valid", 128'(fin_valid), 128'(0));
    chk("s3_end_ready", 128'(ent_ready), 128'(1));

    // Scenario 4: three back-to-back entries
`ifdef SVM_FIN_SEQ_PERF_EN
    ec0 = int'(entry_count);
`endif
    ent_v_features = fv3; ent_a_features = fa3; ent_valid = 1'b1;
    xfers = 0;
    for (int c = 0; c < 9; c++) begin
      tick();
      if (c == 8) ent_valid = 1'b0;
      chk("s4_valid", 128'(fin_valid), 128'((c % 3) != 2));
      chk("s4_mod", 128'(fin_modality), 128'((c % 3) == 1));
      chk("s4_ready", 128'(ent_ready), 128'((c % 3) == 2));
      if (fin_valid && fin_ready) xfers++;
    end
    chk("s4_xfers", 128'(xfers), 128'(6));
`ifdef SVM_FIN_SEQ_PERF_EN
    chk("s4_entry_count", 128'(int'(entry_count) - ec0), 128'(3));
`endif

    // Scenario 5: reset while stalled in the arousal beat
    ent_v_features = fv2; ent_a_features = fa2; ent_valid = 1'b1; fin_ready = 1'b1;
    tick();
    ent_valid = 1'b0;
    tick();
    fin_ready = 1'b0;
    chk("s5_a_mod", 128'(fin_modality), 128'(1));
    tick();
    chk("s5_a_hold", 128'(in_features), 128'(fa2));
    rst = 1'b1;
    tick();
    chk("s5_rst_valid", 128'(fin_valid), 128'(0));
    chk("s5_rst_feat", 128'(in_features), 128'(0));
    rst = 1'b0;
    tick();
    chk("s5_ready", 128'(ent_ready), 128'(1));
    ent_v_features = fv4; ent_a_features = fa4; ent_valid = 1'b1; fin_ready = 1'b1;
    tick();
    ent_valid = 1'b0;
    chk("s5_new_mod", 128'(fin_modality), 128'(0));
    chk("s5_new_feat", 128'(in_features), 128'(fv4));
    tick();
    chk("s5_new_a_feat", 128'(in_features), 128'(fa4));
    tick();

    // Scenario 6: ent_valid pulse during the valence beat is ignored
    ent_v_features = fv1; ent_a_features = fa1; ent_valid = 1'b1; fin_ready = 1'b0;
    tick();
    ent_v_features = fv3; ent_a_features = fa3; ent_valid = 1'b1;
    tick();
    ent_valid = 1'b0;
    chk("s6_v_feat", 128'(in_features), 128'(fv1));
    chk("s6_v_ready", 128'(ent_ready), 128'(0));
    fin_ready = 1'b1;
    tick();
    chk("s6_a_feat", 128'(in_features), 128'(fa1));
    tick();
    chk("s6_idle_valid", 128'(fin_valid), 128'(0));
    tick();
    chk("s6_no_capture", 128'(fin_valid), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
